bj_hand: RTL and testbench

- Consumer end of the card-generator interface in the blackjack design.
- Requests cards from the pseudo-random card generator by pulsing its count enable, and accumulates the hand total with soft-ace handling.
- Sequences the initial two-card deal, then player HIT/STAND decisions (or the automatic dealer rule), and flags bust, blackjack and hand completion.
- One instance serves the player hand and one the dealer hand.

---
 rtl/bj_hand.sv | 160 ++++++++++++++++
 tb/tb_bj_hand.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bj_hand.sv
// Blackjack hand accumulator: pulls cards from the card generator, keeps the
// soft-ace adjusted total and sequences the deal, hit/stand or dealer draw.
module bj_hand #(
  parameter bit          DEALER_MODE = 1'b0,
  parameter int unsigned HIT_LIMIT   = 17,
  parameter int unsigned MAX_CARDS   = 8
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       start_i,
  input  logic       hit_i,
  input  logic       stand_i,
  input  logic [3:0] card_i,
  output logic       enc_o,
  output logic [4:0] score_o,
  output logic [3:0] ncards_o,
  output logic [3:0] last_card_o,
  output logic       soft_o,
  output logic       ready_o,
  output logic       bust_o,
  output logic       bj_o,
  output logic       done_o
);

  localparam int unsigned SW = 5;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_ADJ,
    S_WAIT,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [NW-1:0]   ncards_q, ncards_d;
  logic [CW-1:0]   last_q, last_d;
  logic [NW-1:0]   aces_q, aces_d;
  logic            soft_q, soft_d;
  logic            ready_q, ready_d;
  logic            bust_q, bust_d;
  logic            bj_q, bj_d;
  logic            done_q, done_d;

  logic [CW-1:0]   card_v;
  logic            do_adj;
  logic [SW-1:0]   adj_score;

  // Face codes 12..15 count as 10; one soft ace is demoted when over 21.
  assign card_v    = (card_i > CW'(11)) ? CW'(10) : card_i;
  assign do_adj    = (score_q > SW'(21)) && (aces_q != '0);
  assign adj_score = do_adj ? (score_q - SW'(10)) : score_q;

  assign enc_o = (state_q == S_DRAW) && res_n_i && (card_i != '0);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    ncards_d = ncards_q;
    last_d   = last_q;
    aces_d   = aces_q;
    bust_d   = bust_q;
    bj_d     = bj_q;

    case (state_q)
      S_IDLE: ;
      S_DRAW: begin
        if (card_i != '0) begin
          score_d  = score_q + SW'(card_v);
          ncards_d = ncards_q + NW'(1);
          last_d   = card_v;
          if (card_v == CW'(11)) aces_d = aces_q + NW'(1);
          state_d  = S_ADJ;
        end
      end
      S_ADJ: begin
        score_d = adj_score;
        if (do_adj) aces_d = aces_q - NW'(1);
        if (adj_score > SW'(21)) begin
          bust_d  = 1'b1;
          state_d = S_FIN;
        end else if (adj_score == SW'(21)) begin
          if (ncards_q == NW'(2)) bj_d = 1'b1;
          state_d = S_FIN;
        end else if (ncards_q == NW'(MAX_CARDS)) begin
          state_d = S_FIN;
        end else if (ncards_q < NW'(2)) begin
          state_d = S_DRAW;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DEALER_MODE) begin
          state_d = (score_q < SW'(HIT_LIMIT)) ? S_DRAW : S_FIN;
        end else if (stand_i) begin
          state_d = S_FIN;
        end else if (hit_i) begin
          state_d = S_DRAW;
        end
      end
      S_FIN: ;
      default: state_d = S_IDLE;
    endcase

    // A new hand pre-empts whatever is in progress.
    if (start_i) begin
      state_d  = S_DRAW;
      score_d  = '0;
      ncards_d = '0;
      last_d   = '0;
      aces_d   = '0;
      bust_d   = 1'b0;
      bj_d     = 1'b0;
    end

    soft_d  = (aces_d != '0);
    ready_d = (state_d == S_WAIT) && !DEALER_MODE;
    done_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      ncards_q <= '0;
      last_q   <= '0;
      aces_q   <= '0;
      soft_q   <= 1'b0;
      ready_q  <= 1'b0;
      bust_q   <= 1'b0;
      bj_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      ncards_q <= ncards_d;
      last_q   <= last_d;
      aces_q   <= aces_d;
      soft_q   <= soft_d;
      ready_q  <= ready_d;
      bust_q   <= bust_d;
      bj_q     <= bj_d;
      done_q   <= done_d;
    end
  end

  assign score_o     = score_q;
  assign ncards_o    = ncards_q;
  assign last_card_o = last_q;
  assign soft_o      = soft_q;
  assign ready_o     = ready_q;
  assign bust_o      = bust_q;
  assign bj_o        = bj_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_bj_hand.sv
// Bench for bj_hand: directed scenarios plus random hands scored by a
// card-list blackjack model, with a queue standing in for the card generator.
module tb_bj_hand;

  localparam int unsigned MAXC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] card;
  logic       p_start, p_hit, p_stand, d_start, d_hit, d_stand;
  logic       p_enc, p_soft, p_ready, p_bust, p_bj, p_done;
  logic       d_enc, d_soft, d_ready, d_bust, d_bj, d_done;
  logic [4:0] p_score, d_score;
  logic [3:0] p_ncards, d_ncards, p_last, d_last;

  int deck[$];
  bit take;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bj_hand #(.DEALER_MODE(1'b0), .HIT_LIMIT(17), .MAX_CARDS(MAXC)) u_player (
    .clk_i(clk), .res_n_i(rst_n), .start_i(p_start), .hit_i(p_hit), .stand_i(p_stand),
    .card_i(card), .enc_o(p_enc), .score_o(p_score), .ncards_o(p_ncards),
    .last_card_o(p_last), .soft_o(p_soft), .ready_o(p_ready), .bust_o(p_bust),
    .bj_o(p_bj), .done_o(p_done)
  );

  bj_hand #(.DEALER_MODE(1'b1), .HIT_LIMIT(17), .MAX_CARDS(MAXC)) u_dealer (
    .clk_i(clk), .res_n_i(rst_n), .start_i(d_start), .hit_i(d_hit), .stand_i(d_stand),
    .card_i(card), .enc_o(d_enc), .score_o(d_score), .ncards_o(d_ncards),
    .last_card_o(d_last), .soft_o(d_soft), .ready_o(d_ready), .bust_o(d_bust),
    .bj_o(d_bj), .done_o(d_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic show();
    card = (deck.size() > 0) ? 4'(deck[0]) : 4'd0;
  endtask

  // One clock: the generator advances on a consumed card, and a shown zero lasts one cycle.
  task automatic step();
    @(negedge clk);
    take = p_enc || d_enc || (card == 4'd0 && deck.size() > 0);
    @(posedge clk);
    #1;
    if (take && deck.size() > 0) void'(deck.pop_front());
    show();
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_enc"},    int'(p_enc), 0);
    check({tag, "_score"},  int'(p_score), 0);
    check({tag, "_ncards"}, int'(p_ncards), 0);
    check({tag, "_last"},   int'(p_last), 0);
    check({tag, "_flags"},  int'({p_soft, p_ready, p_bust, p_bj, p_done}), 0);
    check({tag, "_d_enc"},  int'(d_enc), 0);
  endtask

  task automatic wait_p(input string tag, input bit want_done);
    int k = 0;
    while (k < 60 && !(want_done ? p_done : p_ready)) begin
      step();
      k++;
    end
    check(tag, int'(want_done ? p_done : p_ready), 1);
  endtask

  task automatic start_p();
    p_start = 1'b1;
    step();
    p_start = 1'b0;
  endtask

  task automatic run_dealer(output int encs, output int rdy);
    int k = 0;
    encs = 0;
    rdy  = 0;
    d_hit = 1'b1;
    d_stand = 1'b1;
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    while (k < 60 && !d_done) begin
      encs += int'(d_enc);
      rdy  |= int'(d_ready);
      step();
      k++;
    end
    d_hit = 1'b0;
    d_stand = 1'b0;
    check("dl_done", int'(d_done), 1);
  endtask

  // Standard blackjack total: aces as 1, one of them promoted to 11 if it fits.
  function automatic int best(input int hard, input int aces);
    return (aces > 0 && hard + 10 <= 21) ? hard + 10 : hard;
  endfunction

  task automatic play(input bit dl);
    int hard = 0, aces = 0, n = 0, last = 0, v, sc, act;
    bit stood = 0, fin = 0, e, r, term;
    deck.delete();
    for (int i = 0; i < 40; i++)
      deck.push_back(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15)));
    show();
    if (dl) d_start = 1'b1; else p_start = 1'b1;
    step();
    p_start = 1'b0;
    d_start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (dl ? d_done : p_done) begin
        fin = 1;
      end else begin
        e = dl ? d_enc : p_enc;
        r = dl ? d_ready : p_ready;
        if (e) begin
          v = (card > 4'd11) ? 10 : int'(card);
          hard += (v == 11) ? 1 : v;
          aces += (v == 11) ? 1 : 0;
          n++;
          last = v;
        end
        if (r) begin
          sc = best(hard, aces);
          check("rnd_w_score", int'(p_score), sc);
          check("rnd_w_soft", int'(p_soft), int'(sc != hard));
          check("rnd_w_ncards", int'(p_ncards), n);
          check("rnd_w_last", int'(p_last), last);
          check("rnd_w_live", int'(sc < 21 && n < int'(MAXC) && n >= 2), 1);
          act = int'($urandom_range(0, 3));
          p_hit = (act & 1) != 0;
          p_stand = (act & 2) != 0;
          if (p_stand) stood = 1;
        end
        step();
        p_hit = 1'b0;
        p_stand = 1'b0;
      end
    end
    check("rnd_finish", int'(fin), 1);
    sc = best(hard, aces);
    term = (sc >= 21) || (n == int'(MAXC)) || (dl ? (sc >= 17) : stood);
    check("rnd_term", int'(term), 1);
    check("rnd_score", int'(dl ? d_score : p_score), sc);
    check("rnd_ncards", int'(dl ? d_ncards : p_ncards), n);
    check("rnd_last", int'(dl ? d_last : p_last), last);
    check("rnd_soft", int'(dl ? d_soft : p_soft), int'(sc != hard));
    check("rnd_bust", int'(dl ? d_bust : p_bust), int'(sc > 21));
    check("rnd_bj", int'(dl ? d_bj : p_bj), int'(sc == 21 && n == 2));
    check("rnd_ready", int'(dl ? d_ready : p_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int encs, rdy, prev, dbl;

    // Reset overrides START with a valid card present.
    rst_n = 1'b0;
    p_start = 1'b1; p_hit = 1'b0; p_stand = 1'b0;
    d_start = 1'b1; d_hit = 1'b0; d_stand = 1'b0;
    deck = '{5};
    show();
    step();
    check("rst_enc1", int'(p_enc | d_enc), 0);
    step();
    check_zero("rst");
    rst_n = 1'b1;
    p_start = 1'b0;
    d_start = 1'b0;
    #1;
    check("idle_enc", int'(p_enc), 0);
    step();
    check_zero("idle");

    // Ace + ten: blackjack straight from the deal.
    deck = '{11, 10};
    show();
    start_p();
    encs = 0; rdy = 0; prev = 0; dbl = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("bj_enc_latency", int'(p_enc), 1);
      if (prev != 0 && p_enc) dbl = 1;
      prev = int'(p_enc);
      encs += int'(p_enc);
      rdy  |= int'(p_ready);
      step();
    end
    check("bj_encs", encs, 2);
    check("bj_enc_single", dbl, 0);
    check("bj_ready_seen", rdy, 0);
    check("bj_score", int'(p_score), 21);
    check("bj_flag", int'(p_bj), 1);
    check("bj_done", int'(p_done), 1);
    check("bj_ncards", int'(p_ncards), 2);
    check("bj_soft", int'(p_soft), 1);
    check("bj_bust", int'(p_bust), 0);

    // Two aces, then a ten drops the last soft ace; HIT+STAND stands.
    deck = '{11, 11};
    show();
    start_p();
    wait_p("aa_ready", 1'b0);
    check("aa_score", int'(p_score), 12);
    check("aa_soft", int'(p_soft), 1);
    deck.push_back(10);
    show();
    p_hit = 1'b1;
    step();
    p_hit = 1'b0;
    check("hit_enc_latency", int'(p_enc), 1);
    wait_p("aa10_ready", 1'b0);
    check("aa10_score", int'(p_score), 12);
    check("aa10_soft", int'(p_soft), 0);
    check("aa10_ncards", int'(p_ncards), 3);
    deck.push_back(9);
    show();
    p_hit = 1'b1;
    p_stand = 1'b1;
    step();
    p_hit = 1'b0;
    p_stand = 1'b0;
    check("stand_done", int'(p_done), 1);
    check("stand_enc", int'(p_enc), 0);
    step();
    check("stand_score", int'(p_score), 12);
    check("stand_bust", int'(p_bust), 0);
    check("stand_ncards", int'(p_ncards), 3);

    // Bust on a hit, then later HITs are ignored.
    deck = '{10, 6};
    show();
    start_p();
    wait_p("b_ready", 1'b0);
    deck = '{9};
    show();
    p_hit = 1'b1;
    step();
    p_hit = 1'b0;
    wait_p("b_done", 1'b1);
    check("b_score", int'(p_score), 25);
    check("b_bust", int'(p_bust), 1);
    check("b_last", int'(p_last), 9);
    deck = '{5};
    show();
    p_hit = 1'b1;
    encs = 0;
    for (int i = 0; i < 3; i++) begin
      encs += int'(p_enc);
      step();
    end
    p_hit = 1'b0;
    check("b_post_encs", encs, 0);
    check("b_post_ncards", int'(p_ncards), 3);

    // Dealer draws to 17 and ignores HIT/STAND.
    deck = '{2, 3, 4, 5, 6};
    show();
    run_dealer(encs, rdy);
    check("dl_encs", encs, 5);
    check("dl_ready_seen", rdy, 0);
    check("dl_score", int'(d_score), 20);
    check("dl_ncards", int'(d_ncards), 5);
    check("dl_last", int'(d_last), 6);
    deck = '{9, 13};
    show();
    run_dealer(encs, rdy);
    check("dl13_encs", encs, 2);
    check("dl13_score", int'(d_score), 19);
    check("dl13_last", int'(d_last), 10);

    // Empty generator output stalls DRAW without consuming.
    deck = '{0, 0, 0, 0, 7, 4};
    show();
    start_p();
    for (int i = 0; i < 3; i++) begin
      check("zero_enc", int'(p_enc), 0);
      check("zero_ncards", int'(p_ncards), 0);
      step();
    end
    check("zero_then_enc", int'(p_enc), 1);
    step();
    check("zero_ncards_after", int'(p_ncards), 1);
    check("zero_last", int'(p_last), 7);
    check("zero_score", int'(p_score), 7);

    // Reset asserted while DRAW has a card pending.
    deck = '{8};
    show();
    start_p();
    check("mid_enc_before", int'(p_enc), 1);
    rst_n = 1'b0;
    #1;
    check("mid_enc_rst", int'(p_enc), 0);
    step();
    check_zero("mid_rst");
    rst_n = 1'b1;
    step();
    check_zero("mid_idle");

    for (int h = 0; h < 25; h++) play(1'b0);
    for (int h = 0; h < 15; h++) play(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
